// File: rtl/regfile_write_arbiter.sv
// Register bank write-port owner: init sweep, then round-robin
// arbitration of two valid/ready write requesters onto one port.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   reqX_valid/addr/data/ready
//                     write requesters 0 and 1 (ready = accepted now)
//   init_start        one-cycle request to re-run the init sweep
//   busy              high while the init sweep is active
//   zero_drop         pulse: accepted write to r0 was discarded
//   rf_we/addr/data   registered bank write port
module regfile_write_arbiter #(
    parameter int              N        = 4,
    parameter int              W        = 16,
    parameter logic [W-1:0]    INIT_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_addr,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_addr,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    input  logic         init_start,
    output logic         busy,
    output logic         zero_drop,
    output logic         rf_we,
    output logic [N-1:0] rf_addr,
    output logic [W-1:0] rf_data
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t       state_q, state_d;
    // Sweep pointer; wrapping to 0 marks the end of the sweep,
    // which is safe because r0 is never a sweep target.
    logic [N-1:0] ptr_q, ptr_d;
    // 0: favour req0, 1: favour req1
    logic         rr_q, rr_d;

    logic         we_d, zd_d, busy_d;
    logic [N-1:0] addr_d;
    logic [W-1:0] data_d;

    logic         grant_ok;
    logic         gnt0, gnt1;
    logic [N-1:0] win_addr;
    logic [W-1:0] win_data;

    // No transfer is offered in reset, during the sweep, or
    // while a re-sweep is being requested.
    assign grant_ok = rst && (state_q == S_RUN) && !init_start;
    assign gnt0 = grant_ok && req0_valid && (!req1_valid || !rr_q);
    assign gnt1 = grant_ok && req1_valid && (!req0_valid || rr_q);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign win_addr = gnt1 ? req1_addr : req0_addr;
    assign win_data = gnt1 ? req1_data : req0_data;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_INIT;
            ptr_q     <= N'(1);
            rr_q      <= 1'b0;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
            zero_drop <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rr_q      <= rr_d;
            rf_we     <= we_d;
            rf_addr   <= addr_d;
            rf_data   <= data_d;
            zero_drop <= zd_d;
            busy      <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT: begin
                if (ptr_q == '0) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (init_start) begin
                    state_d = S_INIT;
                end
            end
        endcase
    end

    // Next values of the registered outputs and pointers
    always_comb begin
        we_d   = 1'b0;
        zd_d   = 1'b0;
        addr_d = rf_addr;
        data_d = rf_data;
        ptr_d  = ptr_q;
        rr_d   = rr_q;
        busy_d = (state_d == S_INIT);
        unique case (state_q)
            S_INIT: begin
                if (ptr_q != '0) begin
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    data_d = INIT_VAL;
                    ptr_d  = ptr_q + N'(1);
                end
            end
            S_RUN: begin
                if (init_start) begin
                    ptr_d = N'(1);
                end else if (gnt0 || gnt1) begin
                    addr_d = win_addr;
                    data_d = win_data;
                    we_d   = (win_addr != '0);
                    zd_d   = (win_addr == '0);
                    // Favour whichever requester did not just win
                    rr_d   = gnt0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;

    localparam int            N    = 4;
    localparam int            W    = 16;
    localparam int            NREG = 1 << N;
    localparam logic [W-1:0]  INIT = 16'h0000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0;
    logic [N-1:0] req0_addr = '0;
    logic [W-1:0] req0_data = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [N-1:0] req1_addr = '0;
    logic [W-1:0] req1_data = '0;
    logic         req1_ready;
    logic         init_start = 1'b0;
    logic         busy;
    logic         zero_drop;
    logic         rf_we;
    logic [N-1:0] rf_addr;
    logic [W-1:0] rf_data;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter #(.N(N), .W(W), .INIT_VAL(INIT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .init_start(init_start), .busy(busy), .zero_drop(zero_drop),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: sweep is a counter of remaining addresses,
    // arbitration is "favoured one wins a tie, favour the loser next".
    int           m_run  = 0;
    int           m_next = 1;
    int           m_fav  = 0;
    logic         e_we = 0, e_zd = 0, e_busy = 1;
    logic [N-1:0] e_addr = '0;
    logic [W-1:0] e_data = '0;
    logic [W-1:0] exp_mem [NREG];
    logic [W-1:0] dut_mem [NREG];

    function automatic int exp_winner();
        if (!rst || m_run == 0 || init_start) return -1;
        if (req0_valid && req1_valid) return m_fav;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        int a;
        if (rf_we) dut_mem[rf_addr] = rf_data;
        w = exp_winner();
        if (!rst) begin
            m_run = 0; m_next = 1; m_fav = 0;
            e_we = 0; e_addr = '0; e_data = '0; e_zd = 0; e_busy = 1;
        end else if (m_run == 0) begin
            e_zd = 0;
            if (m_next < NREG) begin
                e_we = 1; e_addr = N'(m_next); e_data = INIT;
                exp_mem[m_next] = INIT;
                m_next = m_next + 1;
                e_busy = 1;
            end else begin
                e_we = 0; e_busy = 0; m_run = 1;
            end
        end else if (init_start) begin
            m_run = 0; m_next = 1; e_we = 0; e_zd = 0; e_busy = 1;
        end else if (w >= 0) begin
            a = (w == 0) ? int'(req0_addr) : int'(req1_addr);
            e_addr = N'(a);
            e_data = (w == 0) ? req0_data : req1_data;
            e_we = (a != 0);
            e_zd = (a == 0);
            if (a != 0) exp_mem[a] = e_data;
            m_fav = 1 - w;
        end else begin
            e_we = 0; e_zd = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
        checks++; if (rf_addr !== '0) begin errors++; $display("FAIL reset_addr got=%0h exp=0", rf_addr); end
        checks++; if (rf_data !== '0) begin errors++; $display("FAIL reset_data got=%0h exp=0", rf_data); end
        checks++; if (zero_drop !== 1'b0) begin errors++; $display("FAIL reset_zd got=%0b exp=0", zero_drop); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%0b exp=1", busy); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
        rst = 1'b1;
    endtask

    task automatic test_sweep();
        int n = 0;
        bit done = 0;
        req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 16'h1234;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL sweep_ready got=%b exp=00", {req0_ready, req1_ready}); end
            tick();
            if (rf_we === 1'b1) begin
                n++;
                checks++; if (rf_addr !== N'(n) || rf_data !== INIT || busy !== 1'b1) begin errors++; $display("FAIL sweep_write got=%0h/%0h/%0b exp=%0h/%0h/1", rf_addr, rf_data, busy, n, INIT); end
            end else begin
                done = 1;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_busy_fall got=%0b exp=0", busy); end
            end
        end
        req0_valid = 1'b0;
        checks++; if (n != NREG - 1 || !done) begin errors++; $display("FAIL sweep_count got=%0d exp=%0d", n, NREG - 1); end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'hAAAA;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 4'd3 || rf_data !== 16'hAAAA) begin errors++; $display("FAIL single_write got=%0b/%0h/%0h exp=1/3/aaaa", rf_we, rf_addr, rf_data); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b exp=0", rf_we); end
        checks++; if (dut_mem[3] !== 16'hAAAA) begin errors++; $display("FAIL single_bank got=%0h exp=aaaa", dut_mem[3]); end
    endtask

    task automatic test_zero();
        req1_valid = 1'b1; req1_addr = 4'd0; req1_data = 16'hABCD;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL zero_ready got=%b exp=01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 1'b0;
        checks++; if (rf_we !== 1'b0 || zero_drop !== 1'b1) begin errors++; $display("FAIL zero_drop_pulse got=%0b/%0b exp=0/1", rf_we, zero_drop); end
        tick();
        checks++; if (zero_drop !== 1'b0) begin errors++; $display("FAIL zero_drop_end got=%0b exp=0", zero_drop); end
        checks++; if (dut_mem[0] !== 16'h0000) begin errors++; $display("FAIL zero_bank got=%0h exp=0", dut_mem[0]); end
    endtask

    task automatic test_back_to_back();
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 16'h1111;
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_grant%0d got=%b", i, {req0_ready, req1_ready}); end
            tick();
            checks++; if (rf_we !== 1'b1 || rf_addr !== ((i % 2 == 0) ? 4'd1 : 4'd2)) begin errors++; $display("FAIL b2b_write%0d got=%0b/%0h", i, rf_we, rf_addr); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        checks++; if (dut_mem[1] !== 16'h1111 || dut_mem[2] !== 16'h2222) begin errors++; $display("FAIL b2b_bank got=%0h/%0h exp=1111/2222", dut_mem[1], dut_mem[2]); end
    endtask

    task automatic test_init_start();
        int writes = 0;
        int busy_cycles = 0;
        bit done = 0;
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'hBEEF;
        init_start = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL istart_ready got=%0b exp=0", req0_ready); end
        tick();
        init_start = 1'b0;
        checks++; if (busy !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL istart_enter got=%0b/%0b exp=1/0", busy, rf_we); end
        busy_cycles = 1;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL istart_hold_ready got=%0b exp=0", req0_ready); end
            tick();
            if (rf_we === 1'b1) writes++;
            if (busy === 1'b1) busy_cycles++;
            else done = 1;
        end
        checks++; if (writes != NREG - 1 || busy_cycles != NREG) begin errors++; $display("FAIL istart_sweep got=%0d/%0d exp=%0d/%0d", writes, busy_cycles, NREG - 1, NREG); end
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL istart_accept got=%0b exp=1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 4'd5 || rf_data !== 16'hBEEF) begin errors++; $display("FAIL istart_write got=%0b/%0h/%0h exp=1/5/beef", rf_we, rf_addr, rf_data); end
        tick();
        checks++; if (dut_mem[5] !== 16'hBEEF) begin errors++; $display("FAIL istart_bank got=%0h exp=beef", dut_mem[5]); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit hit = 0;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            tick();
            if (rf_we === 1'b1 && rf_addr === 4'd7) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL midrst_reach7 got=%0h exp=7", rf_addr); end
        rst = 1'b0;
        tick();
        checks++; if (rf_we !== 1'b0 || rf_addr !== '0 || rf_data !== '0 || busy !== 1'b1 || zero_drop !== 1'b0) begin errors++; $display("FAIL midrst_values got=%0b/%0h/%0h/%0b/%0b exp=0/0/0/1/0", rf_we, rf_addr, rf_data, busy, zero_drop); end
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rf_we === 1'b1) begin
                n++;
                checks++; if (rf_addr !== N'(n)) begin errors++; $display("FAIL midrst_addr got=%0h exp=%0h", rf_addr, n); end
            end
            if (busy === 1'b0) break;
        end
        checks++; if (n != NREG - 1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_count got=%0d/%0b exp=%0d/0", n, busy, NREG - 1); end
    endtask

    task automatic test_random();
        bit p0 = 0, p1 = 0;
        int w;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1; req0_addr = N'($urandom_range(0, NREG - 1)); req0_data = W'($urandom);
            end
            if (!p1 && $urandom_range(0, 1) == 1) begin
                p1 = 1; req1_addr = N'($urandom_range(0, NREG - 1)); req1_data = W'($urandom);
            end
            req0_valid = p0; req1_valid = p1;
            init_start = ($urandom_range(0, 79) == 0);
            #1;
            w = exp_winner();
            checks++; if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp_winner=%0d", c, {req0_ready, req1_ready}, w); end
            tick();
            if (w == 0) p0 = 0;
            if (w == 1) p1 = 0;
            checks++; if (rf_we !== e_we || zero_drop !== e_zd || busy !== e_busy) begin errors++; $display("FAIL rand_ctl c=%0d got=%0b%0b%0b exp=%0b%0b%0b", c, rf_we, zero_drop, busy, e_we, e_zd, e_busy); end
            if (e_we) begin
                checks++; if (rf_addr !== e_addr || rf_data !== e_data) begin errors++; $display("FAIL rand_wdata c=%0d got=%0h/%0h exp=%0h/%0h", c, rf_addr, rf_data, e_addr, e_data); end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; init_start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        for (int i = 0; i < NREG; i++) begin
            checks++; if (dut_mem[i] !== exp_mem[i]) begin errors++; $display("FAIL rand_bank r%0d got=%0h exp=%0h", i, dut_mem[i], exp_mem[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            exp_mem[i] = '0;
            dut_mem[i] = '0;
        end
        #1;
        test_reset();
        test_sweep();
        test_single();
        test_zero();
        test_back_to_back();
        test_init_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
